// File: rtl/rr_resource_scheduler_if.sv
// Bundle between requester FSMs and the round-robin scheduler: request/done in,
// registered grant vector, grant index, busy/timeout status and FSM state out.
interface rr_resource_scheduler_if #(
    parameter int N = 5
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    // Handshake: a requester raises req[i] and holds it level-high until it
    // either pulses done[i] while granted or drops req[i] (abandon). grant is
    // one-hot or zero, and only the owner's done/req bits affect a live grant.
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;
    logic [1:0]     dbg_state;

    modport master (
        output req, done,
        input  grant, grant_id, busy, timeout, dbg_state
    );

    modport slave (
        input  req, done,
        output grant, grant_id, busy, timeout, dbg_state
    );
endinterface

// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler for one multi-cycle resource with a 1-cycle turnaround gap.
// Define HOLD_TIMEOUT_EN to forcibly revoke grants held for MAX_HOLD cycles.
module rr_resource_scheduler #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    rr_resource_scheduler_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDW:0] N_W = (IDW + 1)'(N);

    if (N < 1 || MAX_HOLD < 1) begin : g_bad_params
        $error("rr_resource_scheduler: N and MAX_HOLD must both be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW:0]   cand;
    logic [IDW:0]   ptr_inc;
    logic           owner_done;
    logic           owner_req;
    logic           hold_expired;
    logic           release_now;

    // Cyclic search starting at the pointer; the sum stays below 2N so one
    // conditional subtract is enough to wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && bus.req[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, gid_q} + (IDW + 1)'(1);
        if (ptr_inc >= N_W) begin
            ptr_inc = '0;
        end
    end

    assign owner_done  = bus.done[gid_q];
    assign owner_req   = bus.req[gid_q];
    assign release_now = owner_done || !owner_req || hold_expired;

`ifdef HOLD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Counter reads 1 on the first grant cycle, so a value of MAX_HOLD means
    // the grant has been visible for exactly MAX_HOLD cycles.
    assign hold_expired = (state_q == BUSY) && (cnt_q == CW'(MAX_HOLD)) &&
                          !owner_done && owner_req;

    always_comb begin
        cnt_d     = '0;
        timeout_d = hold_expired;
        if (state_d == BUSY) begin
            cnt_d = (state_q == BUSY) ? cnt_q + CW'(1) : CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE, GAP: begin
                grant_d = '0;
                if (found) begin
                    grant_d[pick] = 1'b1;
                    gid_d         = pick;
                    state_d       = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (release_now) begin
                    grant_d = '0;
                    ptr_d   = ptr_inc[IDW-1:0];
                    state_d = GAP;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = |grant_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed and constrained-random bench for rr_resource_scheduler (N=5).
module tb_rr_resource_scheduler;
    localparam int N        = 5;
    localparam int MAX_HOLD = 16;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] grant;
        logic [2:0]   gid;
        logic         chk_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_resource_scheduler_if #(.N(N)) bus ();

    rr_resource_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [N-1:0] exp_q[$];
    vec_t vecs[20];

    always @(negedge clk) begin
        if (!rst) begin
            assert ($onehot0(bus.grant)) else $error("grant has more than one bit set: %b", bus.grant);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int held;
        int timeout_seen;
        int worst;
        int waitc[N];
        logic [N-1:0] req_n, done_n, req_edge, prev_grant;
        logic [N-1:0] cur;

        vecs = '{
            '{1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b1},
            '{1'b0, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b0, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b0, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b0, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b0, 5'b00100, 5'b00100, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b10100, 5'b00000, 5'b10000, 3'd4, 1'b1},
            '{1'b0, 5'b10100, 5'b00001, 5'b10000, 3'd4, 1'b1},
            '{1'b0, 5'b10100, 5'b10000, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b10100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b0, 5'b10100, 5'b00100, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1},
            '{1'b1, 5'b10000, 5'b00000, 5'b00000, 3'd0, 1'b1},
            '{1'b0, 5'b10000, 5'b00000, 5'b10000, 3'd4, 1'b1},
            '{1'b0, 5'b10000, 5'b10000, 5'b00000, 3'd0, 1'b0},
            '{1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0}
        };

        // Reset state
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = '0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);

        // Table: single request, pointer advance/wrap, ignored non-owner done,
        // sole-requester regrant, abandon, reset mid-grant
        for (int v = 0; v < 20; v++) begin
            rst      = vecs[v].rst;
            bus.req  = vecs[v].req;
            bus.done = vecs[v].done;
            tick();
            check($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'(vecs[v].grant));
            check($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(|vecs[v].grant));
            check($sformatf("vec%0d_timeout", v), 32'(bus.timeout), 32'd0);
            if (vecs[v].chk_id) begin
                check($sformatf("vec%0d_gid", v), 32'(bus.grant_id), 32'(vecs[v].gid));
            end
        end

        // All requesting: strict rotation with one empty cycle between owners
        do_reset();
        exp_q = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        bus.req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            cur = exp_q.pop_front();
            check($sformatf("rr_order%0d", k), 32'(bus.grant), 32'(cur));
            tick();
            check($sformatf("rr_hold%0d", k), 32'(bus.grant), 32'(cur));
            bus.done = bus.grant;
            tick();
            bus.done = '0;
            check($sformatf("rr_gap%0d", k), 32'(bus.grant), 32'd0);
        end

        // Abandon by owner 1 while a non-owner pulses done
        do_reset();
        bus.req = 5'b00010;
        tick();
        check("ab_grant1", 32'(bus.grant), 32'b00010);
        bus.req  = 5'b01010;
        bus.done = 5'b00001;
        tick();
        check("ab_ignore_done0", 32'(bus.grant), 32'b00010);
        bus.done = '0;
        bus.req  = 5'b01000;
        tick();
        check("ab_release", 32'(bus.grant), 32'd0);
        bus.req = 5'b01010;
        tick();
        check("ab_next_owner3", 32'(bus.grant), 32'b01000);

        // Owner that never signals done
        do_reset();
        bus.req = 5'b00001;
        tick();
`ifdef HOLD_TIMEOUT_EN
        held = 0;
        while (bus.grant[0] && held < 200) begin
            held++;
            tick();
        end
        check("to_held_cycles", 32'(held), 32'(MAX_HOLD));
        check("to_pulse", 32'(bus.timeout), 32'd1);
        check("to_grant_drop", 32'(bus.grant), 32'd0);
        tick();
        check("to_pulse_end", 32'(bus.timeout), 32'd0);
        check("to_regrant", 32'(bus.grant), 32'b00001);
        for (int i = 1; i < MAX_HOLD; i++) tick();
        check("to_still_held", 32'(bus.grant), 32'b00001);
        bus.done = 5'b00001;
        tick();
        bus.done = '0;
        check("to_done_at_limit_drop", 32'(bus.grant), 32'd0);
        check("to_done_at_limit_no_pulse", 32'(bus.timeout), 32'd0);
`else
        held         = 0;
        timeout_seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus.grant == 5'b00001) held++;
            if (bus.timeout) timeout_seen++;
            tick();
        end
        check("nto_held_cycles", 32'(held), 32'd120);
        check("nto_no_timeout", 32'(timeout_seen), 32'd0);
        bus.done = 5'b00001;
        tick();
        bus.done = '0;
        check("nto_done_release", 32'(bus.grant), 32'd0);
`endif

        // Random traffic: invariants and starvation bound
        do_reset();
        worst = 0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            req_n  = bus.req;
            done_n = '0;
            for (int i = 0; i < N; i++) begin
                if (bus.grant[i]) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    if (r < 3) begin
                        done_n[i] = 1'b1;
                        req_n[i]  = 1'($urandom_range(0, 1));
                    end else if (r == 3) begin
                        req_n[i] = 1'b0;
                    end
                end else if (!bus.req[i]) begin
                    req_n[i] = ($urandom_range(0, 3) == 0);
                end
            end
            bus.req    = req_n;
            bus.done   = done_n;
            req_edge   = req_n;
            prev_grant = bus.grant;
            tick();
            check("rnd_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            check("rnd_busy", 32'(bus.busy), 32'(|bus.grant));
            if (prev_grant == '0 && bus.grant != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.grant[i]) waitc[i] = 0;
                    else if (req_edge[i]) waitc[i]++;
                    if (waitc[i] > worst) worst = waitc[i];
                end
            end
        end
        check("rnd_starve_bound", 32'(worst <= N - 1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
